// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: control decode, immediate extend, register file, D->E pipeline register.
module decode_cycle (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrD,
  input  logic [31:0] pcD,
  input  logic [31:0] pcincr4D,
  input  logic        regwriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  input  logic        flushE,
  output logic        regwriteE,
  output logic        memwriteE,
  output logic        jumpE,
  output logic        branchE,
  output logic        alusrcE,
  output logic [1:0]  resultsrcE,
  output logic [2:0]  alucontrolE,
  output logic [31:0] rd1E,
  output logic [31:0] rd2E,
  output logic [31:0] immextE,
  output logic [31:0] pcE,
  output logic [31:0] pcincr4E,
  output logic [4:0]  rs1E,
  output logic [4:0]  rs2E,
  output logic [4:0]  rdE
);

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  alucontrol;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immext;
    logic [31:0] pc;
    logic [31:0] pcincr4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } e_reg_t;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  assign op     = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign rs1    = instrD[19:15];
  assign rs2    = instrD[24:20];
  assign rd     = instrD[11:7];

  logic        regwrite, memwrite, jump, branch, alusrc;
  logic [1:0]  immsrc, resultsrc, aluop;
  logic [2:0]  alucontrol;

  always_comb begin
    regwrite  = 1'b0;
    immsrc    = 2'b00;
    alusrc    = 1'b0;
    memwrite  = 1'b0;
    resultsrc = 2'b00;
    branch    = 1'b0;
    aluop     = 2'b00;
    jump      = 1'b0;
    case (op)
      7'b0000011: begin
        regwrite  = 1'b1;
        alusrc    = 1'b1;
        resultsrc = 2'b01;
      end
      7'b0100011: begin
        immsrc   = 2'b01;
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      7'b0110011: begin
        regwrite = 1'b1;
        aluop    = 2'b10;
      end
      7'b0010011: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluop    = 2'b10;
      end
      7'b1100011: begin
        immsrc = 2'b10;
        branch = 1'b1;
        aluop  = 2'b01;
      end
      7'b1101111: begin
        regwrite  = 1'b1;
        immsrc    = 2'b11;
        resultsrc = 2'b10;
        jump      = 1'b1;
      end
      default: ;
    endcase
  end

  // I-type shifts/adds never subtract: only R-type (op[5]=1) honours funct7[5].
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & instrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  logic [31:0] immext;

  always_comb begin
    immext = '0;
    case (immsrc)
      2'b00: immext = {{20{instrD[31]}}, instrD[31:20]};
      2'b01: immext = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      2'b10: immext = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      2'b11: immext = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      default: immext = '0;
    endcase
  end

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  assign wr_en = regwriteW && (rdW != 5'd0);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[rdW] = resultW;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Write-through: a same-cycle writeback to the read address wins over the stored value.
  logic [31:0] rd1, rd2;

  always_comb begin
    if (rs1 == 5'd0)                rd1 = '0;
    else if (wr_en && rdW == rs1)   rd1 = resultW;
    else                            rd1 = regs_q[rs1];
    if (rs2 == 5'd0)                rd2 = '0;
    else if (wr_en && rdW == rs2)   rd2 = resultW;
    else                            rd2 = regs_q[rs2];
  end

  e_reg_t e_d, e_q;

  always_comb begin
    e_d = '0;
    if (!flushE) begin
      e_d.regwrite   = regwrite;
      e_d.memwrite   = memwrite;
      e_d.jump       = jump;
      e_d.branch     = branch;
      e_d.alusrc     = alusrc;
      e_d.resultsrc  = resultsrc;
      e_d.alucontrol = alucontrol;
      e_d.rd1        = rd1;
      e_d.rd2        = rd2;
      e_d.immext     = immext;
      e_d.pc         = pcD;
      e_d.pcincr4    = pcincr4D;
      e_d.rs1        = rs1;
      e_d.rs2        = rs2;
      e_d.rd         = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign regwriteE   = e_q.regwrite;
  assign memwriteE   = e_q.memwrite;
  assign jumpE       = e_q.jump;
  assign branchE     = e_q.branch;
  assign alusrcE     = e_q.alusrc;
  assign resultsrcE  = e_q.resultsrc;
  assign alucontrolE = e_q.alucontrol;
  assign rd1E        = e_q.rd1;
  assign rd2E        = e_q.rd2;
  assign immextE     = e_q.immext;
  assign pcE         = e_q.pc;
  assign pcincr4E    = e_q.pcincr4;
  assign rs1E        = e_q.rs1;
  assign rs2E        = e_q.rs2;
  assign rdE         = e_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - randomized scoreboard bench for decode_cycle against a behavioural RV32I decode model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrD, pcD, pcincr4D, resultW;
  logic        regwriteW, flushE;
  logic [4:0]  rdW;
  logic        regwriteE, memwriteE, jumpE, branchE, alusrcE;
  logic [1:0]  resultsrcE;
  logic [2:0]  alucontrolE;
  logic [31:0] rd1E, rd2E, immextE, pcE, pcincr4E;
  logic [4:0]  rs1E, rs2E, rdE;

  decode_cycle dut (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .pcD(pcD), .pcincr4D(pcincr4D),
    .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .flushE(flushE),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .jumpE(jumpE), .branchE(branchE),
    .alusrcE(alusrcE), .resultsrcE(resultsrcE), .alucontrolE(alucontrolE),
    .rd1E(rd1E), .rd2E(rd2E), .immextE(immextE), .pcE(pcE), .pcincr4E(pcincr4E),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        regwrite, memwrite, jump, branch, alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  aluctl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } e_t;

  e_t          exp_q[$];
  e_t          msk_q[$];
  logic [31:0] model_rf [32];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic e_t actual_e();
    return {regwriteE, memwriteE, jumpE, branchE, alusrcE, resultsrcE, alucontrolE,
            rd1E, rd2E, immextE, pcE, pcincr4E, rs1E, rs2E, rdE};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (regwriteW && rdW == a) return resultW;
    return model_rf[a];
  endfunction

  // Immediates built by shifting field values into place rather than concatenating.
  function automatic logic [31:0] imm_of(input logic [31:0] ins, input int fmt);
    logic [31:0] i_imm;
    i_imm = 32'($signed(ins) >>> 20);
    case (fmt)
      1: return (i_imm & ~32'h1f) | 32'(ins[11:7]);
      2: return (ins[31] ? 32'hFFFF_F000 : 32'd0) | (32'(ins[7]) << 11)
              | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      3: return (ins[31] ? 32'hFFF0_0000 : 32'd0) | (32'(ins[19:12]) << 12)
              | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return i_imm;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] ins, input string kind);
    if (kind == "beq") return 3'b001;
    if (kind != "R" && kind != "IALU") return 3'b000;
    case (ins[14:12])
      3'd0: return (kind == "R" && ins[30]) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step(input logic rst_active, output e_t e, output e_t m);
    string kind;
    e = '0;
    m = '1;
    if (rst_active) return;
    case (instrD[6:0])
      7'h03: kind = "lw";
      7'h23: kind = "sw";
      7'h33: kind = "R";
      7'h13: kind = "IALU";
      7'h63: kind = "beq";
      7'h6F: kind = "jal";
      default: kind = "other";
    endcase
    if (!flushE) begin
      e.regwrite  = (kind == "lw" || kind == "R" || kind == "IALU" || kind == "jal");
      e.memwrite  = (kind == "sw");
      e.jump      = (kind == "jal");
      e.branch    = (kind == "beq");
      e.alusrc    = (kind == "lw" || kind == "sw" || kind == "IALU");
      e.resultsrc = (kind == "lw") ? 2'b01 : (kind == "jal") ? 2'b10 : 2'b00;
      e.aluctl    = alu_of(instrD, kind);
      e.imm       = imm_of(instrD, kind == "sw" ? 1 : kind == "beq" ? 2 : kind == "jal" ? 3 : 0);
      e.rd1       = model_read(instrD[19:15]);
      e.rd2       = model_read(instrD[24:20]);
      e.pc        = pcD;
      e.pc4       = pcincr4D;
      e.rs1       = instrD[19:15];
      e.rs2       = instrD[24:20];
      e.rd        = instrD[11:7];
      if (kind == "R") m.imm = '0;
    end
    if (regwriteW && rdW != 0) model_rf[rdW] = resultW;
  endtask

  task automatic drive(input logic [31:0] ins, input logic rw, input logic [4:0] rdw,
                       input logic [31:0] res, input logic fl, input logic rst);
    e_t e, m;
    @(negedge clk);
    rst_n     = rst;
    instrD    = ins;
    pcD       = $urandom;
    pcincr4D  = pcD + 32'd4;
    regwriteW = rw;
    rdW       = rdw;
    resultW   = res;
    flushE    = fl;
    model_step(!rst, e, m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (actual_e() != '0) begin
      miscompares++;
      $display("FAIL %s: got %h required all-zero", name, actual_e());
    end
  endtask

  function automatic logic [31:0] rand_instr(input logic [4:0] hint);
    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    int          k;
    ins = $urandom;
    k = $urandom_range(0, 6);
    case (k)
      0: op = 7'h03;
      1: op = 7'h23;
      2: op = 7'h33;
      3: op = 7'h13;
      4: op = 7'h63;
      5: op = 7'h6F;
      default: begin
        op = 7'($urandom);
        while (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 || op == 7'h63 || op == 7'h6F)
          op = 7'($urandom);
      end
    endcase
    case ($urandom_range(0, 4))
      0: f3 = 3'd0;
      1: f3 = 3'd2;
      2: f3 = 3'd6;
      3: f3 = 3'd7;
      default: f3 = 3'($urandom);
    endcase
    ins[6:0]   = op;
    ins[14:12] = f3;
    if ($urandom_range(0, 3) == 0) ins[19:15] = hint;
    if ($urandom_range(0, 3) == 0) ins[24:20] = hint;
    return ins;
  endfunction

  task automatic rand_vec(input logic rst);
    logic [4:0] rdw;
    rdw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    drive(rand_instr(rdw), 1'($urandom_range(0, 1)), rdw, $urandom,
          $urandom_range(0, 7) == 0, rst);
  endtask

  initial begin : monitor
    e_t e, m, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        a = actual_e();
        vectors++;
        if (((a ^ e) & m) != '0) begin
          miscompares++;
          $display("FAIL e_outputs @%0t: got %h required %h (mask %h)", $time, a, e, m);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; instrD = '0; pcD = '0; pcincr4D = 32'd4;
    regwriteW = 1'b0; rdW = '0; resultW = '0; flushE = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    #1;
    check_zero("reset_state");

    drive(32'h0050_0093, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drive(32'h0001_8233, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    drive(32'h0001_8233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drive(32'h0000_0033, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1);
    drive(32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drive(32'hFE00_0EE3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drive(32'hFE00_0EE3, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    drive(32'h0000_0033, 1'b1, 5'd5, 32'h5555_AAAA, 1'b1, 1'b1);

    for (int n = 0; n < 200; n++) rand_vec(1'b1);

    // Reset lands between edges, with a writeback to x5 still pending.
    @(negedge clk);
    regwriteW = 1'b1; rdW = 5'd5; resultW = 32'h1234_5678;
    @(posedge clk);
    for (int i = 1; i < 32; i++) if (regwriteW) model_rf[rdW] = resultW;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("mid_cycle_reset");
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    for (int n = 0; n < 3; n++) rand_vec(1'b0);
    drive(32'h0052_8333, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    for (int n = 0; n < 200; n++) rand_vec(1'b1);

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
